// File: rtl/mznm_pkg.sv
// Shared widths and opcode constants for the 16-bit core pipeline.
package mznm_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NREGS      = 2 ** REG_ADDR_W;
  localparam int OP_W       = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 5'd0,
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_AND = 5'd3,
    OP_OR  = 5'd4,
    OP_XOR = 5'd5,
    OP_LDI = 5'd6,
    OP_MOV = 5'd7
  } opcode_e;
endpackage

// File: rtl/of_scoreboard.sv
// Per-register busy bits: one bit per architectural register with a pending write.
module of_scoreboard
  import mznm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic                  i_kill_en,
  input  logic [REG_ADDR_W-1:0] i_kill_addr,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic [REG_ADDR_W-1:0] i_look_src1,
  input  logic [REG_ADDR_W-1:0] i_look_src2,
  input  logic [REG_ADDR_W-1:0] i_look_dst,
  output logic                  o_busy_src1,
  output logic                  o_busy_src2,
  output logic                  o_busy_dst,
  output logic [NREGS-1:0]      o_busy
);
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  // Clears first, set last, so a new writer claiming a register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_en)  w_busy_next[i_clr_addr]  = 1'b0;
    if (i_kill_en) w_busy_next[i_kill_addr] = 1'b0;
    if (i_set_en)  w_busy_next[i_set_addr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign o_busy_src1 = r_busy[i_look_src1];
  assign o_busy_src2 = r_busy[i_look_src2];
  assign o_busy_dst  = r_busy[i_look_dst];
  assign o_busy      = r_busy;
endmodule

// File: rtl/operand_fetch.sv
// Decode->execute stage: operand gather with writeback bypass, scoreboard hazard stall,
// and a single registered payload slot. Handshake: a beat transfers when valid && ready.
module operand_fetch
  import mznm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic [REG_ADDR_W-1:0] in_src1,
  input  logic [REG_ADDR_W-1:0] in_src2,
  input  logic                  in_use1,
  input  logic                  in_use2,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic                  in_wen,
  input  logic [DATA_W-1:0]     in_imm,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_W-1:0]       out_op,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [DATA_W-1:0]     out_imm,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic                  out_wen,
  output logic [NREGS-1:0]      dbg_busy
);
  logic                  r_valid;
  logic [OP_W-1:0]       r_op;
  logic [DATA_W-1:0]     r_a, r_b, r_imm;
  logic [REG_ADDR_W-1:0] r_dst;
  logic                  r_wen;

  logic w_hit1, w_hit2, w_hitd;
  logic w_busy1, w_busy2, w_busyd;
  logic w_raw, w_waw, w_space, w_accept;
  logic [DATA_W-1:0] w_opa, w_opb;

  assign rf_raddr1 = in_src1;
  assign rf_raddr2 = in_src2;

  assign w_hit1 = wb_en && (wb_addr == in_src1);
  assign w_hit2 = wb_en && (wb_addr == in_src2);
  assign w_hitd = wb_en && (wb_addr == in_dst);

  // A register being written back this cycle is already resolved: bypass it, do not stall.
  assign w_opa = w_hit1 ? wb_data : rf_rdata1;
  assign w_opb = w_hit2 ? wb_data : rf_rdata2;

  assign w_raw    = (in_use1 && w_busy1 && !w_hit1) || (in_use2 && w_busy2 && !w_hit2);
  assign w_waw    = in_wen && w_busyd && !w_hitd;
  assign w_space  = !r_valid || out_ready;
  assign in_ready = w_space && !w_raw && !w_waw && !flush;
  assign w_accept = in_valid && in_ready;

  of_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_clr_en    (wb_en),
    .i_clr_addr  (wb_addr),
    .i_kill_en   (flush && r_valid && r_wen),
    .i_kill_addr (r_dst),
    .i_set_en    (w_accept && in_wen),
    .i_set_addr  (in_dst),
    .i_look_src1 (in_src1),
    .i_look_src2 (in_src2),
    .i_look_dst  (in_dst),
    .o_busy_src1 (w_busy1),
    .o_busy_src2 (w_busy2),
    .o_busy_dst  (w_busyd),
    .o_busy      (dbg_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_dst   <= '0;
      r_wen   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_op    <= in_op;
      r_a     <= w_opa;
      r_b     <= w_opb;
      r_imm   <= in_imm;
      r_dst   <= in_dst;
      r_wen   <= in_wen;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_op    = r_op;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_imm   = r_imm;
  assign out_dst   = r_dst;
  assign out_wen   = r_wen;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run against a behavioural model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_op;
  logic [2:0]  in_src1, in_src2, in_dst;
  logic        in_use1, in_use2, in_wen;
  logic [15:0] in_imm;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [4:0]  out_op;
  logic [15:0] out_a, out_b, out_imm;
  logic [2:0]  out_dst;
  logic        out_wen;
  logic [7:0]  dbg_busy;

  int total = 0;
  int bad   = 0;

  // Register file behind the stage, plus the reference model state.
  logic [15:0] tb_rf [8];
  logic [7:0]  m_busy;
  bit          m_valid;
  logic [4:0]  m_op;
  logic [15:0] m_a, m_b, m_imm;
  logic [2:0]  m_dst;
  bit          m_wen;

  always #5 clk = ~clk;

  assign rf_rdata1 = tb_rf[rf_raddr1];
  assign rf_rdata2 = tb_rf[rf_raddr2];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
    .in_dst(in_dst), .in_wen(in_wen), .in_imm(in_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_dst(out_dst), .out_wen(out_wen),
    .dbg_busy(dbg_busy)
  );

  function automatic bit m_hit(input logic [2:0] r);
    return wb_en && (wb_addr == r);
  endfunction

  function automatic bit m_ready();
    bit src_blocked, dst_blocked, room;
    src_blocked = (in_use1 && m_busy[in_src1] && !m_hit(in_src1)) ||
                  (in_use2 && m_busy[in_src2] && !m_hit(in_src2));
    dst_blocked = in_wen && m_busy[in_dst] && !m_hit(in_dst);
    room        = !m_valid || out_ready;
    return room && !src_blocked && !dst_blocked && !flush;
  endfunction

  function automatic logic [15:0] m_operand(input logic [2:0] r);
    return m_hit(r) ? wb_data : tb_rf[r];
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    bit          acc, do_wr;
    logic [7:0]  nb;
    logic [2:0]  wr_a;
    logic [15:0] wr_d;
    @(posedge clk);
    do_wr = wb_en;
    wr_a  = wb_addr;
    wr_d  = wb_data;
    if (rst) begin
      m_busy = '0; m_valid = 0; m_op = '0; m_a = '0; m_b = '0;
      m_imm = '0; m_dst = '0; m_wen = 0;
    end else begin
      acc = in_valid && m_ready();
      nb  = m_busy;
      if (wb_en) nb[wb_addr] = 1'b0;
      if (flush && m_valid && m_wen) nb[m_dst] = 1'b0;
      if (acc && in_wen) nb[in_dst] = 1'b1;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_op = in_op; m_a = m_operand(in_src1); m_b = m_operand(in_src2);
        m_imm = in_imm; m_dst = in_dst; m_wen = in_wen;
      end else if (out_ready) m_valid = 0;
      m_busy = nb;
    end
    #1;
    if (do_wr) tb_rf[wr_a] = wr_d;
  endtask

  task automatic idle();
    in_valid = 0; in_op = '0; in_src1 = '0; in_src2 = '0; in_use1 = 0; in_use2 = 0;
    in_dst = '0; in_wen = 0; in_imm = '0; wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] s1, input bit u1,
                       input logic [2:0] s2, input bit u2, input logic [2:0] d,
                       input bit w, input logic [15:0] imm);
    in_valid = 1; in_op = op; in_src1 = s1; in_use1 = u1; in_src2 = s2; in_use2 = u2;
    in_dst = d; in_wen = w; in_imm = imm;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (dbg_busy !== 8'h00) begin bad++; $display("FAIL reset_busy got=%h exp=00", dbg_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
    total++; if ({out_op, out_a, out_b, out_imm, out_dst, out_wen} !== '0) begin
      bad++; $display("FAIL reset_payload got=%h/%h/%h/%h exp=0", out_op, out_a, out_b, out_imm); end
  endtask

  task automatic test_basic();
    do_reset();
    tb_rf[3] = 16'h1234;
    drive(5'd3, 3'd3, 1, 3'd0, 0, 3'd1, 0, 16'hBEEF);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0b exp=1", in_ready); end
    total++; if (rf_raddr1 !== 3'd3) begin bad++; $display("FAIL basic_raddr got=%0d exp=3", rf_raddr1); end
    step();
    idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_a !== 16'h1234 || out_imm !== 16'hBEEF || out_op !== 5'd3) begin
      bad++; $display("FAIL basic_out got v=%0b a=%h imm=%h op=%0d exp v=1 a=1234 imm=beef op=3",
                      out_valid, out_a, out_imm, out_op); end
    step();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_raw_bypass();
    do_reset();
    drive(5'd1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 16'h0001);
    step();
    drive(5'd2, 3'd2, 1, 3'd0, 0, 3'd4, 0, 16'h0002);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%0b exp=0", in_ready); end
      step();
    end
    total++; if (dbg_busy[2] !== 1'b1) begin bad++; $display("FAIL raw_busy got=%0b exp=1", dbg_busy[2]); end
    wb_en = 1; wb_addr = 3'd2; wb_data = 16'h00AB;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_release got=%0b exp=1", in_ready); end
    step();
    idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_a !== 16'h00AB) begin
      bad++; $display("FAIL raw_bypass got v=%0b a=%h exp v=1 a=00ab", out_valid, out_a); end
    total++; if (dbg_busy[2] !== 1'b0) begin bad++; $display("FAIL raw_clear got=%0b exp=0", dbg_busy[2]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 0;
    drive(5'd7, 3'd1, 1, 3'd0, 0, 3'd0, 0, 16'h1111);
    step();
    drive(5'd9, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 16'h1111 || out_op !== 5'd7) begin
        bad++; $display("FAIL hold got rdy=%0b v=%0b imm=%h op=%0d exp rdy=0 v=1 imm=1111 op=7",
                        in_ready, out_valid, out_imm, out_op); end
      step();
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    step();
    idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_imm !== 16'h2222 || out_op !== 5'd9) begin
      bad++; $display("FAIL b2b_next got v=%0b imm=%h op=%0d exp v=1 imm=2222 op=9", out_valid, out_imm, out_op); end
  endtask

  task automatic test_waw();
    do_reset();
    drive(5'd1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 16'h0005);
    step();
    drive(5'd1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 16'h5555);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL waw_stall got=%0b exp=0", in_ready); end
      step();
    end
    wb_en = 1; wb_addr = 3'd5; wb_data = 16'h0F0F;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL waw_release got=%0b exp=1", in_ready); end
    step();
    idle();
    @(negedge clk);
    total++; if (dbg_busy !== 8'h20 || out_imm !== 16'h5555) begin
      bad++; $display("FAIL waw_keep got busy=%h imm=%h exp busy=20 imm=5555", dbg_busy, out_imm); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    drive(5'd4, 3'd0, 0, 3'd0, 0, 3'd6, 1, 16'h6666);
    step();
    drive(5'd5, 3'd1, 1, 3'd2, 1, 3'd3, 0, 16'h7777);
    out_ready = 1;
    flush = 1;
    #1;
    total++; if (in_ready !== 1'b0 || dbg_busy !== 8'h40) begin
      bad++; $display("FAIL flush_block got rdy=%0b busy=%h exp rdy=0 busy=40", in_ready, dbg_busy); end
    step();
    idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || dbg_busy !== 8'h00) begin
      bad++; $display("FAIL flush_squash got v=%0b busy=%h exp v=0 busy=00", out_valid, dbg_busy); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(5'd6, 3'd0, 0, 3'd0, 0, 3'(i), 1, 16'hA000 + 16'(i));
      step();
    end
    idle();
    out_ready = 0;
    @(negedge clk);
    total++; if (dbg_busy !== 8'hFF || out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_setup got busy=%h v=%0b exp busy=ff v=1", dbg_busy, out_valid); end
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || dbg_busy !== 8'h00 || out_imm !== 16'h0 || out_dst !== 3'd0 || out_wen !== 1'b0) begin
      bad++; $display("FAIL mid_reset got v=%0b busy=%h imm=%h dst=%0d wen=%0b exp all 0",
                      out_valid, dbg_busy, out_imm, out_dst, out_wen); end
  endtask

  task automatic test_random();
    logic [7:0] pend;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)), 16'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 2) != 0);
      wb_addr   = 3'($urandom_range(0, 7));
      pend      = m_busy;
      if (pend != 0 && $urandom_range(0, 3) != 0)
        while (!pend[wb_addr]) wb_addr = 3'($urandom_range(0, 7));
      wb_data   = 16'($urandom);
      @(negedge clk);
      total++; if (in_ready !== m_ready()) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, in_ready, m_ready()); end
      total++; if (out_valid !== m_valid || dbg_busy !== m_busy) begin
        bad++; $display("FAIL rnd_state c=%0d got v=%0b busy=%h exp v=%0b busy=%h",
                        c, out_valid, dbg_busy, m_valid, m_busy); end
      if (m_valid) begin
        total++;
        if ({out_op, out_a, out_b, out_imm, out_dst, out_wen} !== {m_op, m_a, m_b, m_imm, m_dst, m_wen}) begin
          bad++; $display("FAIL rnd_payload c=%0d got op=%0d a=%h b=%h imm=%h dst=%0d wen=%0b exp op=%0d a=%h b=%h imm=%h dst=%0d wen=%0b",
                          c, out_op, out_a, out_b, out_imm, out_dst, out_wen,
                          m_op, m_a, m_b, m_imm, m_dst, m_wen);
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    for (int r = 0; r < 8; r++) tb_rf[r] = 16'(r * 16'h0101);
    m_busy = '0; m_valid = 0; m_op = '0; m_a = '0; m_b = '0; m_imm = '0; m_dst = '0; m_wen = 0;
    idle();
    out_ready = 1;
    rst = 1;
    test_reset();
    test_basic();
    test_raw_bypass();
    test_back_to_back();
    test_waw();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
